// File: rtl/job_fetch.sv
// job_fetch: per-channel job descriptor fetcher.
// Issues a single-beat AXI4 read for one 128-byte descriptor. The descriptor
// address comes from a 512-entry, 64-bit per-channel address table, and the
// descriptor is handed to the requesting engine channel.
// After each good fetch, the table entry advances by 128 bytes.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   fetch_ram_*                   register-interface writes into the address table
//   fetch_req_i/chnl_i/ready_o    fetch request handshake from the scheduler
//   desc_*                        descriptor output handshake to the engine
//   m_axi_ar* / m_axi_r*          AXI4 read address / read data channels
module job_fetch #(
    parameter int unsigned ID_WIDTH     = 1,
    parameter int unsigned ARUSER_WIDTH = 9,
    parameter int unsigned DATA_WIDTH   = 1024,
    parameter int unsigned ADDR_WIDTH   = 64
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic [8:0]              fetch_ram_addr_i,
    input  logic                    fetch_ram_hi_i,
    input  logic                    fetch_ram_lo_i,
    input  logic [31:0]             fetch_ram_data_i,

    input  logic                    fetch_req_i,
    input  logic [8:0]              fetch_chnl_i,
    output logic                    fetch_ready_o,

    output logic                    desc_valid_o,
    input  logic                    desc_ready_i,
    output logic [DATA_WIDTH-1:0]   desc_data_o,
    output logic [8:0]              desc_chnl_o,
    output logic                    desc_err_o,

    output logic [ID_WIDTH-1:0]     m_axi_arid,
    output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [7:0]              m_axi_arlen,
    output logic [2:0]              m_axi_arsize,
    output logic [1:0]              m_axi_arburst,
    output logic [3:0]              m_axi_arcache,
    output logic                    m_axi_arlock,
    output logic [2:0]              m_axi_arprot,
    output logic [3:0]              m_axi_arqos,
    output logic [ARUSER_WIDTH-1:0] m_axi_aruser,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    input  logic [ID_WIDTH-1:0]     m_axi_rid,
    input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rlast,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready
);

    localparam int unsigned CHNL_W     = 9;
    localparam int unsigned DEPTH      = 512;
    localparam logic [63:0] DESC_BYTES = 64'd128;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AR,
        ST_R,
        ST_OUT,
        ST_UPD
    } state_t;

    state_t                state, state_nxt;
    logic [CHNL_W-1:0]     chnl, chnl_nxt;
    logic [63:0]           cur_addr, cur_addr_nxt;
    logic                  ovr, ovr_nxt;
    logic                  arvalid_nxt, rready_nxt, desc_valid_nxt, fetch_ready_nxt;
    logic                  desc_err_nxt;
    logic [DATA_WIDTH-1:0] desc_data_nxt;
    logic [CHNL_W-1:0]     desc_chnl_nxt;
    logic                  upd_we;
    logic                  reg_wr;
    logic [63:0]           tbl_rd;
    logic [63:0]           nxt_addr;

    logic [31:0] mem_lo [DEPTH];
    logic [31:0] mem_hi [DEPTH];

    // The response ID is not checked because only one read is ever outstanding.
    logic unused_rid;
    assign unused_rid = ^m_axi_rid;

    assign reg_wr   = fetch_ram_hi_i | fetch_ram_lo_i;
    assign tbl_rd   = {mem_hi[chnl], mem_lo[chnl]};
    assign nxt_addr = cur_addr + DESC_BYTES;

    // Fixed AR attributes: one 128-byte INCR beat, tagged with the channel.
    assign m_axi_arid    = '0;
    assign m_axi_araddr  = ADDR_WIDTH'(tbl_rd);
    assign m_axi_arlen   = 8'd0;
    assign m_axi_arsize  = 3'd7;
    assign m_axi_arburst = 2'b01;
    assign m_axi_arcache = 4'd3;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arprot  = 3'd0;
    assign m_axi_arqos   = 4'd0;
    assign m_axi_aruser  = ARUSER_WIDTH'(chnl);

    // Address table. Host register writes always win over the post-fetch advance.
    always_ff @(posedge clk) begin
        if (fetch_ram_lo_i)
            mem_lo[fetch_ram_addr_i] <= fetch_ram_data_i;
        else if (upd_we)
            mem_lo[chnl] <= nxt_addr[31:0];
        if (fetch_ram_hi_i)
            mem_hi[fetch_ram_addr_i] <= fetch_ram_data_i;
        else if (upd_we)
            mem_hi[chnl] <= nxt_addr[63:32];
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt     = state;
        chnl_nxt      = chnl;
        cur_addr_nxt  = cur_addr;
        ovr_nxt       = ovr;
        desc_data_nxt = desc_data_o;
        desc_chnl_nxt = desc_chnl_o;
        desc_err_nxt  = desc_err_o;
        upd_we        = 1'b0;

        case (state)
            ST_IDLE: begin
                if (fetch_req_i) begin
                    chnl_nxt  = fetch_chnl_i;
                    state_nxt = ST_AR;
                end
            end
            ST_AR: begin
                if (m_axi_arready) begin
                    cur_addr_nxt = 64'(m_axi_araddr);
                    state_nxt    = ST_R;
                end
            end
            ST_R: begin
                // A beat without RLAST is a protocol error and is dropped.
                if (m_axi_rvalid && m_axi_rlast) begin
                    desc_data_nxt = m_axi_rdata;
                    desc_chnl_nxt = chnl;
                    desc_err_nxt  = (m_axi_rresp != 2'b00);
                    state_nxt     = ST_OUT;
                end
            end
            ST_OUT: begin
                if (desc_ready_i)
                    state_nxt = desc_err_o ? ST_IDLE : ST_UPD;
            end
            ST_UPD: begin
                // Stall while the RAM write port is busy with a host write.
                if (!reg_wr) begin
                    upd_we    = !ovr;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        // A host write to the in-flight channel after its address was issued
        // wins over the pending advance.
        if (reg_wr && (fetch_ram_addr_i == chnl) &&
            ((state == ST_R) || (state == ST_OUT) || (state == ST_UPD) ||
             ((state == ST_AR) && m_axi_arready)))
            ovr_nxt = 1'b1;
        if (state_nxt == ST_IDLE)
            ovr_nxt = 1'b0;

        fetch_ready_nxt = (state_nxt == ST_IDLE);
        arvalid_nxt     = (state_nxt == ST_AR);
        rready_nxt      = (state_nxt == ST_R);
        desc_valid_nxt  = (state_nxt == ST_OUT);
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            chnl          <= '0;
            cur_addr      <= '0;
            ovr           <= 1'b0;
            fetch_ready_o <= 1'b1;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
            desc_valid_o  <= 1'b0;
            desc_err_o    <= 1'b0;
            desc_data_o   <= '0;
            desc_chnl_o   <= '0;
        end else begin
            state         <= state_nxt;
            chnl          <= chnl_nxt;
            cur_addr      <= cur_addr_nxt;
            ovr           <= ovr_nxt;
            fetch_ready_o <= fetch_ready_nxt;
            m_axi_arvalid <= arvalid_nxt;
            m_axi_rready  <= rready_nxt;
            desc_valid_o  <= desc_valid_nxt;
            desc_err_o    <= desc_err_nxt;
            desc_data_o   <= desc_data_nxt;
            desc_chnl_o   <= desc_chnl_nxt;
        end
    end

endmodule

// File: tb/tb_job_fetch.sv
// Self-checking bench for job_fetch: a scoreboard of expected AR requests and
// descriptors, plus a reference model of the per-channel address table.
module tb_job_fetch;

    logic          clk = 1'b0;
    logic          rst;
    logic [8:0]    fetch_ram_addr_i;
    logic          fetch_ram_hi_i, fetch_ram_lo_i;
    logic [31:0]   fetch_ram_data_i;
    logic          fetch_req_i;
    logic [8:0]    fetch_chnl_i;
    logic          fetch_ready_o;
    logic          desc_valid_o, desc_ready_i, desc_err_o;
    logic [1023:0] desc_data_o;
    logic [8:0]    desc_chnl_o;
    logic [0:0]    m_axi_arid;
    logic [63:0]   m_axi_araddr;
    logic [7:0]    m_axi_arlen;
    logic [2:0]    m_axi_arsize;
    logic [1:0]    m_axi_arburst;
    logic [3:0]    m_axi_arcache;
    logic          m_axi_arlock;
    logic [2:0]    m_axi_arprot;
    logic [3:0]    m_axi_arqos;
    logic [8:0]    m_axi_aruser;
    logic          m_axi_arvalid, m_axi_arready;
    logic [0:0]    m_axi_rid;
    logic [1023:0] m_axi_rdata;
    logic [1:0]    m_axi_rresp;
    logic          m_axi_rlast, m_axi_rvalid, m_axi_rready;

    job_fetch dut (
        .clk(clk), .rst(rst),
        .fetch_ram_addr_i(fetch_ram_addr_i), .fetch_ram_hi_i(fetch_ram_hi_i),
        .fetch_ram_lo_i(fetch_ram_lo_i), .fetch_ram_data_i(fetch_ram_data_i),
        .fetch_req_i(fetch_req_i), .fetch_chnl_i(fetch_chnl_i), .fetch_ready_o(fetch_ready_o),
        .desc_valid_o(desc_valid_o), .desc_ready_i(desc_ready_i), .desc_data_o(desc_data_o),
        .desc_chnl_o(desc_chnl_o), .desc_err_o(desc_err_o),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arcache(m_axi_arcache),
        .m_axi_arlock(m_axi_arlock), .m_axi_arprot(m_axi_arprot), .m_axi_arqos(m_axi_arqos),
        .m_axi_aruser(m_axi_aruser), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] addr;
        logic [8:0]  ch;
    } ar_exp_t;

    typedef struct {
        logic [1023:0] data;
        logic [8:0]    ch;
        logic          err;
    } desc_exp_t;

    ar_exp_t     ar_q[$];
    desc_exp_t   d_q[$];
    logic [63:0] model [512];
    int          n_chk = 0;
    int          n_bad = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [1023:0] mk(input logic [31:0] seed);
        logic [1023:0] r;
        for (int i = 0; i < 32; i++)
            r[i*32 +: 32] = seed ^ (32'(i) * 32'h0101_0101);
        return r;
    endfunction

    // AR scoreboard: compare each accepted address against the oldest expectation.
    always @(negedge clk) begin
        if (!rst && m_axi_arvalid && m_axi_arready) begin
            if (ar_q.size() == 0) begin
                check("ar_unexpected", 128'(1), 128'(0));
            end else begin
                ar_exp_t e;
                e = ar_q.pop_front();
                check("araddr", 128'(m_axi_araddr), 128'(e.addr));
                check("aruser", 128'(m_axi_aruser), 128'(e.ch));
            end
        end
    end

    // Descriptor scoreboard: compare every handshaken descriptor.
    always @(negedge clk) begin
        if (!rst && desc_valid_o && desc_ready_i) begin
            if (d_q.size() == 0) begin
                check("desc_unexpected", 128'(1), 128'(0));
            end else begin
                desc_exp_t e;
                e = d_q.pop_front();
                for (int k = 0; k < 8; k++)
                    check($sformatf("desc_data[%0d]", k), desc_data_o[k*128 +: 128], e.data[k*128 +: 128]);
                check("desc_chnl", 128'(desc_chnl_o), 128'(e.ch));
                check("desc_err", 128'(desc_err_o), 128'(e.err));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    task automatic prog(input logic [8:0] ch, input logic [63:0] val);
        @(posedge clk); #1;
        fetch_ram_addr_i = ch; fetch_ram_hi_i = 1'b1; fetch_ram_data_i = val[63:32];
        @(posedge clk); #1;
        fetch_ram_hi_i = 1'b0; fetch_ram_lo_i = 1'b1; fetch_ram_data_i = val[31:0];
        @(posedge clk); #1;
        fetch_ram_lo_i = 1'b0;
        model[ch] = val;
    endtask

    // One full fetch. hook: 0 none, 1 host writes ch2 lo=0x4000 while in R,
    // 2 host writes ch9 lo=0x600 during the update cycle.
    task automatic fetch(input logic [8:0] ch, input logic [31:0] seed, input logic [1:0] resp,
                         input int ar_wait, input int d_wait, input bit junk, input int hook);
        logic [1023:0] data;
        desc_exp_t     de;
        int            n;
        bit            ovr;
        data = mk(seed);
        ovr  = 1'b0;

        @(posedge clk); #1;
        fetch_req_i = 1'b1; fetch_chnl_i = ch;
        ar_q.push_back('{addr: model[ch], ch: ch});
        n = 0;
        @(negedge clk);
        while (!fetch_ready_o && n < 50) begin @(negedge clk); n++; end
        check("req_wait", 128'(fetch_ready_o), 128'(1));
        @(posedge clk); #1;
        fetch_req_i = 1'b0;

        // Address phase, optionally with AR back-pressure.
        m_axi_arready = (ar_wait == 0);
        @(negedge clk);
        check("ar_latency", 128'(m_axi_arvalid), 128'(1));
        for (int k = 0; k < ar_wait; k++) begin
            check("ar_hold_valid", 128'(m_axi_arvalid), 128'(1));
            check("ar_hold_addr", 128'(m_axi_araddr), 128'(model[ch]));
            @(posedge clk); #1;
            if (k == ar_wait - 1) m_axi_arready = 1'b1;
            @(negedge clk);
        end
        @(posedge clk); #1;
        m_axi_arready = 1'b0;

        // Data phase.
        if (hook == 1) begin
            fetch_ram_addr_i = 9'd2; fetch_ram_lo_i = 1'b1; fetch_ram_data_i = 32'h4000;
            @(posedge clk); #1;
            fetch_ram_lo_i = 1'b0;
            model[2][31:0] = 32'h4000;
            ovr = 1'b1;
        end
        if (junk) begin
            m_axi_rvalid = 1'b1; m_axi_rlast = 1'b0; m_axi_rdata = ~data; m_axi_rresp = 2'b00;
            @(posedge clk); #1;
        end
        m_axi_rvalid = 1'b1; m_axi_rlast = 1'b1; m_axi_rdata = data; m_axi_rresp = resp;
        d_q.push_back('{data: data, ch: ch, err: (resp != 2'b00)});
        n = 0;
        @(negedge clk);
        while (!m_axi_rready && n < 20) begin @(negedge clk); n++; end
        check("r_wait", 128'(m_axi_rready), 128'(1));
        @(posedge clk); #1;
        m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;

        // Output phase, optionally with engine back-pressure.
        desc_ready_i = (d_wait == 0);
        @(negedge clk);
        check("desc_latency", 128'(desc_valid_o), 128'(1));
        for (int k = 0; k < d_wait; k++) begin
            check("desc_hold_valid", 128'(desc_valid_o), 128'(1));
            check("desc_hold_lo", desc_data_o[127:0], data[127:0]);
            check("desc_hold_hi", desc_data_o[1023:896], data[1023:896]);
            @(posedge clk); #1;
            if (k == d_wait - 1) desc_ready_i = 1'b1;
            @(negedge clk);
        end
        @(posedge clk); #1;
        desc_ready_i = 1'b0;

        if (hook == 2) begin
            fetch_ram_addr_i = 9'd9; fetch_ram_lo_i = 1'b1; fetch_ram_data_i = 32'h600;
            @(posedge clk); #1;
            fetch_ram_lo_i = 1'b0;
            model[9][31:0] = 32'h600;
            @(negedge clk);
            check("upd_stall", 128'(fetch_ready_o), 128'(0));
            @(negedge clk);
            check("upd_done", 128'(fetch_ready_o), 128'(1));
        end

        if (resp == 2'b00 && !ovr)
            model[ch] = model[ch] + 64'd128;
    endtask

    initial begin
        rst = 1'b1;
        fetch_ram_addr_i = '0; fetch_ram_hi_i = 1'b0; fetch_ram_lo_i = 1'b0; fetch_ram_data_i = '0;
        fetch_req_i = 1'b0; fetch_chnl_i = '0; desc_ready_i = 1'b0;
        m_axi_arready = 1'b0; m_axi_rid = '0; m_axi_rdata = '0; m_axi_rresp = '0;
        m_axi_rlast = 1'b0; m_axi_rvalid = 1'b0;
        for (int i = 0; i < 512; i++) model[i] = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check("rst_fetch_ready", 128'(fetch_ready_o), 128'(1));
        check("rst_arvalid", 128'(m_axi_arvalid), 128'(0));
        check("rst_rready", 128'(m_axi_rready), 128'(0));
        check("rst_desc_valid", 128'(desc_valid_o), 128'(0));
        check("rst_desc_err", 128'(desc_err_o), 128'(0));
        check("rst_desc_chnl", 128'(desc_chnl_o), 128'(0));
        check("rst_desc_data", desc_data_o[127:0], 128'(0));
        check("arsize", 128'(m_axi_arsize), 128'(7));
        check("arburst", 128'(m_axi_arburst), 128'(1));
        check("arcache", 128'(m_axi_arcache), 128'(3));

        // Basic fetch and post-fetch advance.
        prog(9'd5, 64'h0000_0001_0000_0000);
        fetch(9'd5, 32'hA000_0001, 2'b00, 0, 0, 1'b0, 0);

        // Three back-to-back fetches from a freshly programmed base.
        prog(9'd5, 64'h0000_0001_0000_0000);
        for (int i = 0; i < 3; i++)
            fetch(9'd5, 32'hB000_0000 + 32'(i), 2'b00, 0, 0, 1'b0, 0);

        // 64-bit wrap of the advance.
        prog(9'd7, 64'hFFFF_FFFF_FFFF_FF80);
        fetch(9'd7, 32'hC000_0007, 2'b00, 0, 0, 1'b0, 0);
        check("wrap_model", 128'(model[7]), 128'(0));
        fetch(9'd7, 32'hC100_0007, 2'b00, 0, 0, 1'b0, 0);

        // Error response: no advance, then a refetch preceded by a stray non-last beat.
        prog(9'd3, 64'h0000_0000_0000_2000);
        fetch(9'd3, 32'hD000_0003, 2'b10, 0, 0, 1'b0, 0);
        fetch(9'd3, 32'hD100_0003, 2'b00, 0, 0, 1'b1, 0);

        // Back-pressure on AR and on the descriptor output; only one advance.
        fetch(9'd5, 32'hE000_0005, 2'b00, 10, 5, 1'b0, 0);
        fetch(9'd5, 32'hE100_0005, 2'b00, 0, 0, 1'b0, 0);

        // Host override during the read phase.
        prog(9'd2, 64'h0000_0000_0000_1000);
        fetch(9'd2, 32'hF000_0002, 2'b00, 0, 0, 1'b0, 1);
        fetch(9'd2, 32'hF100_0002, 2'b00, 0, 0, 1'b0, 0);

        // A host write to another channel stalls the update; both land.
        prog(9'd9, 64'h0000_0005_0000_0000);
        fetch(9'd5, 32'h1234_5678, 2'b00, 0, 0, 1'b0, 2);
        fetch(9'd9, 32'h9999_0009, 2'b00, 0, 0, 1'b0, 0);
        fetch(9'd5, 32'h8765_4321, 2'b00, 0, 0, 1'b0, 0);

        repeat (4) @(posedge clk);
        check("ar_q_empty", 128'(ar_q.size()), 128'(0));
        check("d_q_empty", 128'(d_q.size()), 128'(0));

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
